// File: rtl/display_scheduler_if.sv
// Display bus between the scheduler and the panel/LCD driver.
//
// Signals:
//   out_data   - snapshot of the selected channel value (DATA_W bits)
//   out_chan   - index 0..4 of the channel carried in out_data
//   out_valid  - transfer offered by the scheduler
//   out_ready  - transfer accepted by the display driver
//   frame_done - one-cycle pulse after channel 4 has been accepted
//
// Modports:
//   master - scheduler side (drives data/chan/valid/frame_done)
//   slave  - display driver side (drives out_ready)
interface display_scheduler_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] out_data;
    logic [2:0]        out_chan;
    logic              out_valid;
    logic              out_ready;
    logic              frame_done;

    modport master (
        output out_data,
        output out_chan,
        output out_valid,
        output frame_done,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_chan,
        input  out_valid,
        input  frame_done,
        output out_ready
    );
endinterface

// File: rtl/display_scheduler.sv
// Display scheduler: sequences five telemetry channels (voltage, current,
// power, temperature, efficiency) onto one shared display bus with a
// valid/ready handshake. Channels rotate automatically with a programmable
// dwell time after every accepted transfer; hold freezes the rotation on
// the current channel and a forced select jumps straight to a channel.
//
// Ports:
//   clk             - system clock, rising edge
//   reset           - asynchronous active-high reset
//   voltage_in      - channel 0 value
//   current_in      - channel 1 value
//   power_in        - channel 2 value
//   temperature_in  - channel 3 value
//   efficiency_in   - channel 4 value
//   enable          - auto-rotation enable (level)
//   hold            - freeze on the current channel (level)
//   sel_force_valid - request a jump to sel_force
//   sel_force       - forced channel index; values 5..7 are ignored
//   disp            - display bus (master side): out_data, out_chan,
//                     out_valid, out_ready, frame_done
module display_scheduler #(
    parameter int DATA_W       = 12,
    parameter int DWELL_CYCLES = 1000,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     voltage_in,
    input  logic [DATA_W-1:0]     current_in,
    input  logic [DATA_W-1:0]     power_in,
    input  logic [DATA_W-1:0]     temperature_in,
    input  logic [DATA_W-1:0]     efficiency_in,
    input  logic                  enable,
    input  logic                  hold,
    input  logic                  sel_force_valid,
    input  logic [2:0]            sel_force,
    display_scheduler_if.master   disp
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DWELL
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [2:0]       LAST_CHAN  = 3'd4;

    state_t            state_reg,      state_next;
    logic [2:0]        chan_reg,       chan_next;
    logic [DATA_W-1:0] out_data_reg,   out_data_next;
    logic [2:0]        out_chan_reg,   out_chan_next;
    logic              out_valid_reg,  out_valid_next;
    logic              frame_done_reg, frame_done_next;
    logic [CNT_W-1:0]  dwell_reg,      dwell_next;

    logic              force_ok;
    logic [DATA_W-1:0] sel_data;

    // Out-of-range forced indices are simply not a request.
    assign force_ok = sel_force_valid && (sel_force <= LAST_CHAN);

    // Channel multiplexer feeding the snapshot register.
    always_comb begin
        sel_data = '0;
        case (chan_reg)
            3'd0:    sel_data = voltage_in;
            3'd1:    sel_data = current_in;
            3'd2:    sel_data = power_in;
            3'd3:    sel_data = temperature_in;
            3'd4:    sel_data = efficiency_in;
            default: sel_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            chan_reg       <= '0;
            out_data_reg   <= '0;
            out_chan_reg   <= '0;
            out_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            dwell_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            chan_reg       <= chan_next;
            out_data_reg   <= out_data_next;
            out_chan_reg   <= out_chan_next;
            out_valid_reg  <= out_valid_next;
            frame_done_reg <= frame_done_next;
            dwell_reg      <= dwell_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        chan_next       = chan_reg;
        out_data_next   = out_data_reg;
        out_chan_next   = out_chan_reg;
        out_valid_next  = out_valid_reg;
        frame_done_next = 1'b0;
        dwell_next      = dwell_reg;

        case (state_reg)
            IDLE: begin
                out_valid_next = 1'b0;
                if (force_ok) begin
                    chan_next  = sel_force;
                    state_next = LOAD;
                end else if (enable) begin
                    chan_next  = '0;
                    state_next = LOAD;
                end
            end

            LOAD: begin
                // Snapshot taken here keeps out_data stable for the whole
                // SEND phase regardless of input activity.
                out_data_next  = sel_data;
                out_chan_next  = chan_reg;
                out_valid_next = 1'b1;
                state_next     = SEND;
            end

            SEND: begin
                // Once offered, a transfer is never withdrawn; control
                // inputs wait until the dwell phase.
                if (disp.out_ready) begin
                    out_valid_next  = 1'b0;
                    dwell_next      = DWELL_LAST;
                    frame_done_next = (out_chan_reg == LAST_CHAN);
                    state_next      = DWELL;
                end
            end

            DWELL: begin
                if (force_ok) begin
                    chan_next  = sel_force;
                    state_next = LOAD;
                end else if (dwell_reg == '0) begin
                    if (!enable) begin
                        state_next = IDLE;
                    end else if (hold) begin
                        state_next = LOAD;
                    end else begin
                        chan_next  = (chan_reg == LAST_CHAN) ? 3'd0 : chan_reg + 3'd1;
                        state_next = LOAD;
                    end
                end else begin
                    dwell_next = dwell_reg - 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign disp.out_data   = out_data_reg;
    assign disp.out_chan   = out_chan_reg;
    assign disp.out_valid  = out_valid_reg;
    assign disp.frame_done = frame_done_reg;

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler (DWELL_CYCLES = 4).
// Table-driven rotation/hold/force vectors, hand-written stall, disable
// and asynchronous-reset sequences, then randomized traffic checked
// cycle by cycle against a transfer-level reference model.
module tb_display_scheduler;

    localparam int DW    = 12;
    localparam int DWELL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] v_in, i_in, p_in, t_in, e_in;
    logic          enable, hold, fv;
    logic [2:0]    fsel;

    display_scheduler_if #(.DATA_W(DW)) disp();

    display_scheduler #(
        .DATA_W      (DW),
        .DWELL_CYCLES(DWELL),
        .CNT_W       (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .voltage_in     (v_in),
        .current_in     (i_in),
        .power_in       (p_in),
        .temperature_in (t_in),
        .efficiency_in  (e_in),
        .enable         (enable),
        .hold           (hold),
        .sel_force_valid(fv),
        .sel_force      (fsel),
        .disp           (disp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {frame_done, out_valid, out_chan, out_data}
    function automatic logic [16:0] outs();
        return {disp.frame_done, disp.out_valid, disp.out_chan, disp.out_data};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0; hold = 1'b0; fv = 1'b0; fsel = 3'd0;
        disp.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Waits (bounded) for out_valid at a falling edge; clears a force pulse
    // after the first cycle so it is seen by exactly one rising edge.
    task automatic wait_valid(input string name, output bit found);
        found = 1'b0;
        for (int n = 1; n <= 40 && !found; n++) begin
            @(negedge clk);
            if (n == 1) fv = 1'b0;
            if (disp.out_valid) found = 1'b1;
        end
        if (!found) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        bit         hold;
        bit         fv;
        logic [2:0] fsel;
        logic [11:0] i_val;
        logic [2:0] exp_chan;
        logic [11:0] exp_data;
        int         exp_gap;
        bit         exp_frame;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs[NVEC];

    function automatic vec_t mk(bit h, bit f, logic [2:0] fs, logic [11:0] iv,
                                logic [2:0] ch, logic [11:0] d, int g, bit fr);
        vec_t v;
        v.hold = h; v.fv = f; v.fsel = fs; v.i_val = iv;
        v.exp_chan = ch; v.exp_data = d; v.exp_gap = g; v.exp_frame = fr;
        return v;
    endfunction

    // ---------------- reference model ----------------
    // Tracks one outstanding transfer at a time: offered -> accepted ->
    // DWELL waiting cycles (or an earlier valid force) -> next channel is
    // snapshotted one cycle later and offered.
    bit          m_busy, m_dwelling, m_loadnext, m_frame;
    int          m_wait;
    logic [2:0]  m_sel, m_chan;
    logic [11:0] m_data;

    task automatic model_reset();
        m_busy = 0; m_dwelling = 0; m_loadnext = 0; m_frame = 0;
        m_wait = 0; m_sel = 0; m_chan = 0; m_data = 0;
    endtask

    task automatic model_step();
        logic [11:0] vals[5];
        bit force_ok;
        vals = '{v_in, i_in, p_in, t_in, e_in};
        force_ok = fv && (fsel <= 3'd4);
        m_frame = 1'b0;
        if (m_busy) begin
            if (disp.out_ready) begin
                m_busy = 0;
                m_frame = (m_chan == 3'd4);
                m_dwelling = 1;
                m_wait = 0;
            end
        end else if (m_dwelling) begin
            m_wait++;
            if (force_ok) begin
                m_sel = fsel; m_dwelling = 0; m_loadnext = 1;
            end else if (m_wait == DWELL) begin
                m_dwelling = 0;
                if (enable) begin
                    m_sel = hold ? m_chan : 3'((m_chan + 1) % 5);
                    m_loadnext = 1;
                end
            end
        end else if (m_loadnext) begin
            m_chan = m_sel;
            m_data = vals[m_sel];
            m_busy = 1;
            m_loadnext = 0;
        end else if (force_ok) begin
            m_sel = fsel; m_loadnext = 1;
        end else if (enable) begin
            m_sel = 3'd0; m_loadnext = 1;
        end
    endtask

    initial begin
        bit found;
        int prev_cyc;

        vecs[0]  = mk(0, 0, 0, 12'h222, 0, 12'h111, 2, 0);
        vecs[1]  = mk(0, 0, 0, 12'h222, 1, 12'h222, 6, 0);
        vecs[2]  = mk(0, 0, 0, 12'h222, 2, 12'h333, 6, 0);
        vecs[3]  = mk(0, 0, 0, 12'h222, 3, 12'h444, 6, 0);
        vecs[4]  = mk(0, 0, 0, 12'h222, 4, 12'h555, 6, 1);
        vecs[5]  = mk(0, 0, 0, 12'h222, 0, 12'h111, 6, 0);
        vecs[6]  = mk(0, 0, 0, 12'h222, 1, 12'h222, 6, 0);
        vecs[7]  = mk(1, 0, 0, 12'h0AB, 1, 12'h0AB, 6, 0);
        vecs[8]  = mk(0, 0, 0, 12'h0AB, 2, 12'h333, 6, 0);
        vecs[9]  = mk(0, 0, 0, 12'h0AB, 3, 12'h444, 6, 0);
        vecs[10] = mk(0, 0, 0, 12'h0AB, 4, 12'h555, 6, 1);
        vecs[11] = mk(1, 0, 0, 12'h0AB, 4, 12'h555, 6, 1);
        vecs[12] = mk(0, 0, 0, 12'h0AB, 0, 12'h111, 6, 0);
        vecs[13] = mk(0, 1, 3, 12'h0AB, 3, 12'h444, 3, 0);
        vecs[14] = mk(0, 0, 0, 12'h0AB, 4, 12'h555, 6, 1);
        vecs[15] = mk(0, 1, 6, 12'h0AB, 0, 12'h111, 6, 0);
        vecs[16] = mk(0, 0, 0, 12'h0AB, 1, 12'h0AB, 6, 0);

        v_in = 12'h111; i_in = 12'h222; p_in = 12'h333; t_in = 12'h444; e_in = 12'h555;

        // ---- reset state with rotation disabled ----
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("reset_idle", 32'(outs()), 32'd0);
        end

        // ---- table-driven rotation / hold / force ----
        enable = 1'b1;
        prev_cyc = cyc;
        for (int k = 0; k < NVEC; k++) begin
            hold = vecs[k].hold;
            i_in = vecs[k].i_val;
            fv   = vecs[k].fv;
            fsel = vecs[k].fsel;
            wait_valid("vec_valid", found);
            if (found) begin
                check("vec_chan", 32'(disp.out_chan), 32'(vecs[k].exp_chan));
                check("vec_data", 32'(disp.out_data), 32'(vecs[k].exp_data));
                check("vec_gap", 32'(cyc - prev_cyc), 32'(vecs[k].exp_gap));
                $display("xfer %0d: chan %0d data 0x%03h gap %0d", k, disp.out_chan,
                         disp.out_data, cyc - prev_cyc);
                prev_cyc = cyc;
                @(negedge clk);
                check("vec_frame", 32'(disp.frame_done), 32'(vecs[k].exp_frame));
                check("vec_valid_drop", 32'(disp.out_valid), 32'd0);
            end
        end
        @(negedge clk);
        check("frame_one_cycle", 32'(disp.frame_done), 32'd0);
        hold = 1'b0;
        i_in = 12'h222;

        // ---- backpressure on a forced chan-2 transfer, then disable ----
        do_reset();
        disp.out_ready = 1'b0;
        fv = 1'b1; fsel = 3'd2; enable = 1'b1;
        wait_valid("stall_valid", found);
        check("stall_chan", 32'(disp.out_chan), 32'd2);
        check("stall_data", 32'(disp.out_data), 32'h333);
        $display("xfer stall: chan %0d data 0x%03h", disp.out_chan, disp.out_data);
        p_in = 12'h7FF;
        enable = 1'b0;
        hold = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check("stall_hold", 32'(outs()), {15'd0, 1'b0, 1'b1, 3'd2, 12'h333});
        end
        disp.out_ready = 1'b1;
        @(negedge clk);
        check("stall_accept", 32'(disp.out_valid), 32'd0);
        disp.out_ready = 1'b0;
        hold = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("disable_idle", 32'(outs()), {15'd0, 1'b0, 1'b0, 3'd2, 12'h333});
        end
        p_in = 12'h333;

        // ---- asynchronous reset in the middle of SEND ----
        enable = 1'b1;
        wait_valid("rst_valid", found);
        check("rst_chan", 32'(disp.out_chan), 32'd0);
        check("rst_data", 32'(disp.out_data), 32'h111);
        $display("xfer pre-reset: chan %0d data 0x%03h", disp.out_chan, disp.out_data);
        #2 reset = 1'b1;
        #1 check("async_reset", 32'(outs()), 32'd0);
        @(negedge clk);
        enable = 1'b0;
        disp.out_ready = 1'b1;
        reset = 1'b0;

        // ---- randomized traffic against the reference model ----
        model_reset();
        for (int r = 0; r < 3000; r++) begin
            v_in = 12'($urandom); i_in = 12'($urandom); p_in = 12'($urandom);
            t_in = 12'($urandom); e_in = 12'($urandom);
            enable = ($urandom_range(15) != 0);
            hold   = ($urandom_range(3) == 0);
            fv     = ($urandom_range(7) == 0);
            fsel   = 3'($urandom_range(7));
            disp.out_ready = 1'($urandom_range(1));
            model_step();
            @(negedge clk);
            check("random", 32'(outs()), 32'({m_frame, m_busy, m_chan, m_data}));
            if (disp.out_valid && disp.out_ready)
                $display("xfer rand %0d: chan %0d data 0x%03h", r, disp.out_chan, disp.out_data);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Sequences the five 12-bit telemetry channels (voltage, current, power, temperature, efficiency) onto one shared display bus.
- Feeds a downstream display driver over a valid/ready handshake.
- Rotates channels automatically with a programmable dwell time and supports freeze (hold) and a forced channel jump.
- Sits between the registered display values and the single-port panel or LCD driver.

Parameters:
- DATA_W, 12, width of each channel value and of out_data.
- DWELL_CYCLES, 1000, clock cycles spent in DWELL after each accepted transfer; must be >= 1.
- CNT_W, 16, dwell counter width; must hold DWELL_CYCLES-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- voltage_in  in  DATA_W  channel 0 value.
- current_in  in  DATA_W  channel 1 value.
- power_in  in  DATA_W  channel 2 value.
- temperature_in  in  DATA_W  channel 3 value.
- efficiency_in  in  DATA_W  channel 4 value.
- enable  in  1  auto-rotation enable (level).
- hold  in  1  freeze on current channel (level).
- sel_force_valid  in  1  request jump to sel_force.
- sel_force  in  3  forced channel index, 0..4.
- out_data  out  DATA_W  snapshot of the selected channel.
- out_chan  out  3  index of the channel in out_data.
- out_valid  out  1  transfer valid.
- out_ready  in  1  downstream accept.
- frame_done  out  1  one-cycle pulse after channel 4 is accepted.

Behaviour:
- Reset (async, active-high) sets:
  - state=IDLE
  - chan=0, out_chan=0, out_data=0
  - out_valid=0, frame_done=0
  - dwell counter=0
- FSM states: IDLE, LOAD, SEND, DWELL.
- IDLE:
  - out_valid=0.
  - sel_force_valid with sel_force<=4: chan=sel_force, go to LOAD.
  - Otherwise, if enable=1: chan=0, go to LOAD.
  - Force has priority over enable.
- LOAD (exactly one cycle):
  - out_data is loaded from the input selected by chan; out_chan=chan.
  - Go to SEND.
  - out_valid rises on the edge leaving LOAD. Latency from enable sampled high in IDLE to out_valid=1 is 2 clocks.
- SEND:
  - out_valid=1.
  - out_data and out_chan stay stable until out_ready=1. Inputs changing during SEND do not affect out_data.
  - On handshake (out_valid & out_ready): out_valid=0 next cycle, dwell counter=DWELL_CYCLES-1, go to DWELL.
  - enable, hold and sel_force_valid are ignored in SEND. The transfer is never withdrawn.
- DWELL:
  - Counter decrements each cycle.
  - sel_force_valid with sel_force<=4 aborts the dwell: chan=sel_force, go to LOAD next cycle.
  - When counter==0 (and no force):
    - enable=0: go to IDLE, chan unchanged.
    - hold=1: chan unchanged, go to LOAD (resamples the same channel).
    - Otherwise: chan=chan+1 with wrap 4->0, go to LOAD.
  - Handshake to next out_valid=1 is DWELL_CYCLES+1 cycles.
- sel_force values 5..7 are ignored in every state.
- frame_done:
  - Registered pulse, high for exactly one cycle, on the cycle after a handshake with out_chan=4.
  - Also fires when channel 4 is accepted under hold or force.
- Reset asserted mid-SEND drops out_valid asynchronously. No transfer completes.
- out_ready is a don't-care outside SEND.

Test Plan (DWELL_CYCLES=4, out_ready tied 1 unless stated):
- Reset release, enable=0 for 10 cycles -> out_valid=0, out_data=0, out_chan=0, frame_done=0 throughout.
- Inputs V=0x111, I=0x222, P=0x333, T=0x444, E=0x555; enable=1 -> out_valid pulses in order out_chan 0,1,2,3,4,0 with matching data, 6 cycles apart (1 SEND + 4 DWELL + 1 LOAD); frame_done is high one cycle after the chan-4 transfer.
- out_ready=0 for 7 cycles during the chan-2 SEND while power_in changes 0x333->0x7FF -> out_valid held, out_data stays 0x333, no DWELL entry; accepted when out_ready=1.
- hold=1 after the chan-1 transfer, current_in changed to 0x0AB -> repeated chan-1 transfers, second carrying 0x0AB; hold=0 -> next transfer is chan 2.
- In DWELL after chan 0, sel_force_valid=1 with sel_force=3 -> LOAD next cycle, next transfer chan 3 (0x444), then chan 4; sel_force=6 -> ignored, normal rotation.
- enable=0 during SEND of chan 2 -> transfer completes, DWELL runs, then IDLE with out_valid=0; reset asserted mid-SEND -> out_valid=0 immediately, all outputs at reset values.
